adc_scan_sequencer: RTL

//  Frame sequencer for the LTC2308-style serial ADC. Drives ADC_CONVST, ADC_SCLK and
//  ADC_DIN, and captures ADC_DOUT. Steps chan_idx into the channel-select block and

---
 rtl/adc_scan_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - frame sequencer for an LTC2308-style serial ADC
module adc_scan_sequencer #(
    parameter int CLK_DIV       = 2,
    parameter int CONVST_CYCLES = 2,
    parameter int CONV_CYCLES   = 80,
    parameter int NUM_CH        = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        scan_mode,
    input  logic [2:0]  sw_chan,
    output logic [2:0]  chan_idx,
    input  logic [11:0] chansel,
    output logic        ADC_CONVST,
    output logic        ADC_SCLK,
    output logic        ADC_DIN,
    input  logic        ADC_DOUT,
    output logic [11:0] sample_data,
    output logic [2:0]  sample_chan,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVST,
        S_CONV_WAIT,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e      state_q;
    logic [15:0] cnt_q;
    logic [15:0] div_q;
    logic [3:0]  bit_q;
    logic [11:0] cfg_q;
    logic [11:0] shift_q;
    logic [2:0]  chan_idx_q;
    logic [2:0]  cur_tag_q;
    logic [2:0]  prev_tag_q;
    logic        prime_q;
    logic        convst_q;
    logic        sclk_q;
    logic        din_q;
    logic [11:0] data_q;
    logic [2:0]  chan_q;
    logic        valid_q;
    logic        overrun_q;
    logic [2:0]  chan_next_d;

    always_comb begin
        chan_next_d = chan_idx_q + 3'd1;
        if (chan_idx_q == 3'(NUM_CH - 1)) begin
            chan_next_d = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            cfg_q      <= '0;
            shift_q    <= '0;
            chan_idx_q <= '0;
            cur_tag_q  <= '0;
            prev_tag_q <= '0;
            prime_q    <= 1'b1;
            convst_q   <= 1'b0;
            sclk_q     <= 1'b0;
            din_q      <= 1'b0;
            data_q     <= '0;
            chan_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (valid_q && sample_ready) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    convst_q <= 1'b0;
                    sclk_q   <= 1'b0;
                    din_q    <= 1'b0;
                    prime_q  <= 1'b1;
                    if (enable) begin
                        state_q    <= S_CONVST;
                        convst_q   <= 1'b1;
                        cnt_q      <= '0;
                        chan_idx_q <= scan_mode ? 3'd0 : sw_chan;
                    end
                end
                S_CONVST: begin
                    if (cnt_q == 16'(CONVST_CYCLES - 1)) begin
                        state_q  <= S_CONV_WAIT;
                        convst_q <= 1'b0;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_CONV_WAIT: begin
                    if (cnt_q == 16'(CONV_CYCLES - 1)) begin
                        // config shifted now selects the mux for the next conversion
                        state_q   <= S_SHIFT;
                        cfg_q     <= chansel;
                        cur_tag_q <= chan_idx_q;
                        din_q     <= chansel[11];
                        div_q     <= '0;
                        bit_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_SHIFT: begin
                    if (div_q == 16'(CLK_DIV - 1)) begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            sclk_q  <= 1'b1;
                            shift_q <= {shift_q[10:0], ADC_DOUT};
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_q == 4'd11) begin
                                state_q <= S_DONE;
                                din_q   <= 1'b0;
                            end else begin
                                bit_q <= bit_q + 4'd1;
                                din_q <= cfg_q[4'd10 - bit_q];
                            end
                        end
                    end else begin
                        div_q <= div_q + 16'd1;
                    end
                end
                S_DONE: begin
                    prev_tag_q <= cur_tag_q;
                    chan_idx_q <= scan_mode ? chan_next_d : sw_chan;
                    if (!prime_q) begin
                        if (valid_q && !sample_ready) begin
                            overrun_q <= 1'b1;
                        end else begin
                            data_q  <= shift_q;
                            chan_q  <= prev_tag_q;
                            valid_q <= 1'b1;
                        end
                    end
                    if (enable) begin
                        state_q  <= S_CONVST;
                        convst_q <= 1'b1;
                        cnt_q    <= '0;
                        prime_q  <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        prime_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign chan_idx     = chan_idx_q;
    assign ADC_CONVST   = convst_q;
    assign ADC_SCLK     = sclk_q;
    assign ADC_DIN      = din_q;
    assign sample_data  = data_q;
    assign sample_chan  = chan_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != S_IDLE);
    assign overrun      = overrun_q;

endmodule
